pool_reader: RTL
================

# pool_reader

Frame serializer on the read side of the ratio pool. It snapshots the packed `POINTS` × 12-bit quotient vector when the pool signals that a division pass is complete. It then streams the vector out as a byte-framed packet over a valid/ready byte interface for the downstream UART/USB transmitter. A new snapshot can be taken in the same cycle the previous frame finishes, so the pool is never stalled by host-link backpressure beyond one frame.

## Interface
- `POINTS`, 10, number of 12-bit points in `store`.
- `SYNC0`, 8'hA5, first header byte.
- `SYNC1`, 8'h5A, second header byte.

Ports:
- `clk`  in  1  system clock. One clock domain; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `store`  in  12*POINTS  packed quotients. Point k = `store[12*(POINTS-k)-1 -: 12]`, so point 0 is the MSB slice.
- `store_valid`  in  1  one-cycle pulse: `store` is complete and stable this cycle.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte this cycle.
- `busy`  out  1  a frame is in progress; the module is not in IDLE.
- `overrun`  out  1  one-cycle pulse when a `store_valid` is dropped.
- `frame_cnt`  out  8  number of completed frames, mod 256.

## Operation
- Frame layout, `3 + 2*POINTS + 1` bytes (24 for the default):
  - `SYNC0`, `SYNC1`
  - `frame_cnt`
  - for k = 0..POINTS-1: `{4'b0, p_k[11:8]}`, then `p_k[7:0]`
  - CSUM
- CSUM is the 8-bit sum, mod 256, of every byte from `frame_cnt` through the last point low byte. The sync bytes are excluded.
- State machine: IDLE → HDR0 → HDR1 → FCNT → PHI → PLO → (PHI while the point index < POINTS-1, otherwise CSUM) → IDLE.
- A state advances only on a transfer, i.e. `tx_valid && tx_ready` at the clock edge.
- Point index: 0..POINTS-1. It is cleared in IDLE and increments on each PLO transfer.
- Snapshot: `store_valid` sampled in IDLE copies `store` into an internal shadow register. The frame is sent entirely from the shadow; later changes on `store` do not affect the frame in flight.
- `store_valid` during the CSUM transfer cycle is accepted: the shadow reloads and the FSM goes straight to HDR0. There is no gap between frames.
- `store_valid` in any other non-IDLE state (including CSUM without `tx_ready`) is dropped. `overrun` pulses high for exactly the following cycle.
- `frame_cnt` increments on the CSUM transfer and wraps 255 → 0. The FCNT byte carries the value held before that increment.
- The checksum accumulator is cleared on entering HDR0 and accumulates each byte on its transfer from FCNT through PLO.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `busy`=0, `overrun`=0, `frame_cnt`=0, FSM in IDLE, shadow register = 0.
- Reset mid-frame: the frame is aborted. `tx_valid` is 0 from the cycle after the reset edge, and the partial frame is not resumed.
- Latency: `store_valid` high at edge N (in IDLE) → `tx_valid`=1 with `tx_data`=`SYNC0` and `busy`=1 during cycle N+1.
- Handshake rules:
  - `tx_data` and `tx_valid` are registered outputs.
  - Once `tx_valid` is asserted, it stays high and `tx_data` stays stable until the transfer edge.
  - `tx_valid` never depends combinationally on `tx_ready`.
- Throughput: with `tx_ready` held at 1, one byte transfers per cycle. A frame occupies 24 consecutive cycles (default `POINTS`). Back-to-back frames repeat every 24 cycles.
- After a CSUM transfer with no new `store_valid`: in the next cycle `tx_valid`=0 and `busy`=0.
- `tx_ready` while `tx_valid`=0 has no effect.

## Test plan
- After reset, `store`=0, one `store_valid`, `tx_ready`=1 → bytes A5 5A 00, then 20×00, then CSUM 00. `frame_cnt`=1 afterwards. `busy` is high for exactly 24 cycles.
- Second frame with point0=12'hABC and all other points 0 → A5 5A 01 0A BC 18×00, CSUM = (01+0A+BC) mod 256 = 8'hC7. `frame_cnt`=2 afterwards.
- Backpressure: `tx_ready` toggles 1,0,0,1,… randomly; `store` changes mid-frame → byte sequence is identical to the no-stall case, and `tx_data` never changes while `tx_valid && !tx_ready`.
- A `store_valid` in the HDR1 state → one-cycle `overrun` pulse and the current frame is unchanged. A `store_valid` coincident with the CSUM transfer → the next cycle shows `SYNC0` with no idle gap and no `overrun`.
- 256 frames → `frame_cnt` reads 0 after the last frame, and the FCNT byte of frame 256 is FF.
- `rst` asserted during the PHI state of point 3 → next cycle `tx_valid`=0, `busy`=0, `frame_cnt`=0. A new `store_valid` then produces a complete frame starting with A5 5A 00.

Source files
------------

// File: rtl/pool_reader.sv
`default_nettype none
// ============================================================================
//  Module      : pool_reader
//  Description : Snapshots the packed POINTS x 12-bit quotient vector when the
//                ratio pool reports a finished division pass and streams it
//                out as a sync/count/points/checksum byte frame over a
//                valid/ready byte interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_reader #(
    parameter int          POINTS = 10,
    parameter logic [7:0]  SYNC0  = 8'hA5,
    parameter logic [7:0]  SYNC1  = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [12*POINTS-1:0]  store,
    input  logic                  store_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            frame_cnt
);

    localparam int STORE_W = 12 * POINTS;
    localparam int IDX_W   = (POINTS > 1) ? $clog2(POINTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POINTS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_FCNT = 3'd3,
        S_PHI  = 3'd4,
        S_PLO  = 3'd5,
        S_CSUM = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [STORE_W-1:0]   shadow_q, shadow_d;
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           fcnt_q, fcnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 overrun_q, overrun_d;

    logic                 w_xfer;
    logic [11:0]          w_pt [POINTS];

    assign w_xfer = tx_valid_q && tx_ready;

    // Point k sits at the k-th 12-bit slice counted from the MSB end.
    // Slicing the next-state shadow lets the output byte register load the
    // first point of a freshly captured vector without a bubble.
    for (genvar k = 0; k < POINTS; k++) begin : g_pt
        assign w_pt[k] = shadow_d[12*(POINTS-k)-1 -: 12];
    end

    // Next-state, snapshot, checksum, frame counter and overrun detection.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        csum_d    = csum_q;
        fcnt_d    = fcnt_q;
        overrun_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (store_valid) begin
                    shadow_d = store;
                    csum_d   = '0;
                    state_d  = S_HDR0;
                end
            end
            S_HDR0: begin
                if (w_xfer) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_xfer) begin
                    state_d = S_FCNT;
                end
            end
            S_FCNT: begin
                if (w_xfer) begin
                    csum_d  = csum_q + tx_data_q;
                    state_d = S_PHI;
                end
            end
            S_PHI: begin
                if (w_xfer) begin
                    csum_d  = csum_q + tx_data_q;
                    state_d = S_PLO;
                end
            end
            S_PLO: begin
                if (w_xfer) begin
                    csum_d = csum_q + tx_data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_CSUM;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_PHI;
                    end
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    fcnt_d = fcnt_q + 8'd1;
                    idx_d  = '0;
                    // A pass completing exactly as the frame ends is taken
                    // immediately so back-to-back frames have no gap.
                    if (store_valid) begin
                        shadow_d = store;
                        csum_d   = '0;
                        state_d  = S_HDR0;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (store_valid && (state_q != S_IDLE) && !((state_q == S_CSUM) && w_xfer)) begin
            overrun_d = 1'b1;
        end
    end

    // Byte to present next, derived from where the FSM is heading so that
    // tx_data/tx_valid can be registered and hold still across stalls.
    always_comb begin
        tx_valid_d = (state_d != S_IDLE);
        tx_data_d  = 8'h00;
        case (state_d)
            S_HDR0:  tx_data_d = SYNC0;
            S_HDR1:  tx_data_d = SYNC1;
            S_FCNT:  tx_data_d = fcnt_d;
            S_PHI:   tx_data_d = {4'b0000, w_pt[idx_d][11:8]};
            S_PLO:   tx_data_d = w_pt[idx_d][7:0];
            S_CSUM:  tx_data_d = csum_d;
            default: tx_data_d = 8'h00;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            shadow_q   <= '0;
            csum_q     <= '0;
            fcnt_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            csum_q     <= csum_d;
            fcnt_q     <= fcnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign frame_cnt = fcnt_q;

endmodule
`default_nettype wire
